// File: rtl/fp_int_mul_pkg.sv
// Shared types and constants for the bit-serial fp16 x intN multiplier issue path.
// Result struct is packed so it can travel as a plain vector through the FIFO.
package fp_int_mul_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int MANT_ACC_W = 14;
  localparam int PREC_MIN   = 2;
  localparam int PREC_W     = 4;
  localparam int RES_W      = 1 + FP16_EXP_W + MANT_ACC_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [MANT_ACC_W-1:0] mant;
  } res_t;

  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p,
                                                   input logic [PREC_W-1:0] pmax);
    if (p < PREC_W'(PREC_MIN)) return PREC_W'(PREC_MIN);
    if (p > pmax) return pmax;
    return p;
  endfunction

endpackage

// File: rtl/fp_int_res_fifo.sv
// Registered result FIFO; the head is read straight from storage, so a push into an
// empty FIFO becomes visible on the following cycle.
module fp_int_res_fifo
  import fp_int_mul_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [RES_W-1:0] din,
  input  logic             pop,
  output logic [RES_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [RES_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp_int_mul_seq.sv
// Issue controller: serialises sign-magnitude weights to the multiplier and collects
// results, issuing only when a FIFO slot is reserved for every in-flight operation.
module fp_int_mul_seq
  import fp_int_mul_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8,
  parameter int PREC_RST  = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [PREC_W-1:0]     cfg_precision,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACT_WIDTH-1:0]  in_act,
  input  logic [W_MAX-1:0]      in_w,
  output logic                  mul_valid,
  output logic [ACT_WIDTH-1:0]  mul_act,
  output logic                  mul_w,
  output logic [PREC_W-1:0]     mul_precision,
  input  logic                  mul_start_acc,
  input  logic                  mul_sign,
  input  logic [FP16_EXP_W-1:0] mul_exp,
  input  logic [MANT_ACC_W-1:0] mul_mant,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_sign,
  output logic [FP16_EXP_W-1:0] res_exp,
  output logic [MANT_ACC_W-1:0] res_mant,
  output logic                  err_overflow,
  output logic                  err_spurious,
  output logic                  dbg_state
);

  localparam int CW = $clog2(RES_DEPTH);

  // Handshake: an operation transfers on a cycle where in_valid and in_ready are both
  // high; in_ready never depends on in_valid, and in_act/in_w are sampled only then.

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         bc;
  logic [PREC_W-1:0]  prec_q;
  logic [W_MAX-1:0]   w_q;
  logic [CW:0]        inflight;
  logic [CW:0]        fifo_count;
  logic [CW+1:0]      used;
  logic               fifo_full;
  logic               fifo_empty;
  logic               credit_ok;
  logic               last_bit;
  logic               advance;
  logic               accept;
  logic               pop;
  logic               have_inflight;
  logic               retire;
  logic               push;
  logic [2:0]         first_idx;
  logic [2:0]         next_idx;
  res_t               res_in;
  logic [RES_W-1:0]   res_head;

  assign last_bit  = (state == ISSUE) && ({1'b0, bc} == prec_q - 4'd1);
  assign advance   = (state == ISSUE) && !last_bit;
  assign used      = (CW+2)'(fifo_count) + (CW+2)'(inflight);
  assign credit_ok = used < (CW+2)'(RES_DEPTH);
  assign in_ready  = credit_ok & ((state == IDLE) | last_bit) & ~rst;
  assign accept    = in_valid & in_ready;

  assign first_idx = 3'(prec_q - 4'd1);
  assign next_idx  = 3'(prec_q - 4'd2 - {1'b0, bc});

  assign res_valid     = ~fifo_empty;
  assign pop           = res_valid & res_ready;
  assign have_inflight = (inflight != '0);
  assign retire        = mul_start_acc & have_inflight;
  assign push          = retire & (~fifo_full | pop);

  assign mul_valid     = (state == ISSUE);
  assign mul_precision = prec_q;
  assign busy          = (state != IDLE) | have_inflight;
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = ISSUE;
    end else if (last_bit) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mul_w is pre-selected one cycle ahead so the multiplier sees a registered bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc      <= '0;
      w_q     <= '0;
      mul_act <= '0;
      mul_w   <= 1'b0;
    end else if (accept) begin
      bc      <= '0;
      w_q     <= in_w;
      mul_act <= in_act;
      mul_w   <= in_w[first_idx];
    end else if (advance) begin
      bc      <= bc + 3'd1;
      mul_w   <= w_q[next_idx];
    end
  end

  // A load coinciding with an accept is dropped so an operation never sees prec_q move.
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_q <= PREC_W'(PREC_RST);
    end else if (cfg_load && !busy && !accept) begin
      prec_q <= clamp_prec(cfg_precision, PREC_W'(W_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      inflight <= inflight + (CW+1)'(accept) - (CW+1)'(retire);
      if (mul_start_acc && !have_inflight) begin
        err_spurious <= 1'b1;
      end
      if (mul_start_acc && fifo_full && !pop) begin
        err_overflow <= 1'b1;
      end
    end
  end

  assign res_in = '{sign: mul_sign, exp: mul_exp, mant: mul_mant};

  fp_int_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (res_in),
    .pop   (pop),
    .dout  (res_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {res_sign, res_exp, res_mant} = res_head;

endmodule

// File: tb/tb_fp_int_mul_seq.sv
// Directed and randomized checks of the issue controller with a two-entry result FIFO.
module tb_fp_int_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [3:0]  cfg_precision;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_w;
  logic        mul_valid;
  logic [15:0] mul_act;
  logic        mul_w;
  logic [3:0]  mul_precision;
  logic        mul_start_acc;
  logic        mul_sign;
  logic [4:0]  mul_exp;
  logic [13:0] mul_mant;
  logic        res_valid;
  logic        res_ready;
  logic        res_sign;
  logic [4:0]  res_exp;
  logic [13:0] res_mant;
  logic        err_overflow;
  logic        err_spurious;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  fp_int_mul_seq #(
    .ACT_WIDTH (16),
    .W_MAX     (8),
    .PREC_RST  (4),
    .RES_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_load      (cfg_load),
    .cfg_precision (cfg_precision),
    .busy          (busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_act        (in_act),
    .in_w          (in_w),
    .mul_valid     (mul_valid),
    .mul_act       (mul_act),
    .mul_w         (mul_w),
    .mul_precision (mul_precision),
    .mul_start_acc (mul_start_acc),
    .mul_sign      (mul_sign),
    .mul_exp       (mul_exp),
    .mul_mant      (mul_mant),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sign      (res_sign),
    .res_exp       (res_exp),
    .res_mant      (res_mant),
    .err_overflow  (err_overflow),
    .err_spurious  (err_spurious),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit k of the serial stream: k=0 is the sign, then magnitude MSB..LSB.
  function automatic logic exp_bit(input logic [7:0] w, input int prec, input int k);
    int mag;
    if (k == 0) return w[prec-1];
    mag = int'(w) & ((1 << (prec - 1)) - 1);
    return ((mag >> (prec - 1 - k)) & 1) != 0;
  endfunction

  function automatic int clamp(input int p);
    if (p < 2) return 2;
    if (p > 8) return 8;
    return p;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [7:0] w);
    in_valid = 1'b1;
    in_act   = a;
    in_w     = w;
    chk("issue_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_stream(input logic [15:0] a, input logic [7:0] w, input int prec,
                              input logic rdy_last);
    for (int k = 0; k < prec; k++) begin
      chk("mul_valid", mul_valid, 1);
      chk("mul_w", mul_w, exp_bit(w, prec, k));
      chk("mul_act", mul_act, a);
      chk("mul_precision", mul_precision, prec);
      chk("in_ready_stream", in_ready, (k == prec - 1) && rdy_last);
      tick();
    end
  endtask

  task automatic strobe(input logic [19:0] r);
    mul_start_acc = 1'b1;
    {mul_sign, mul_exp, mul_mant} = r;
    tick();
    mul_start_acc = 1'b0;
  endtask

  task automatic pop_chk();
    logic [19:0] e;
    chk("pop_valid", res_valid, 1);
    if (exp_q.size() == 0) begin
      chk("pop_model_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("pop_head", {res_sign, res_exp, res_mant}, e);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic set_prec(input logic [3:0] p);
    cfg_load      = 1'b1;
    cfg_precision = p;
    tick();
    cfg_load      = 1'b0;
    chk("cfg_prec", mul_precision, clamp(int'(p)));
  endtask

  initial begin
    logic [15:0] a0, a1, a2;
    logic [7:0]  w0, w1, w2;
    logic [19:0] r;
    int          prec;

    rst = 1'b1; cfg_load = 0; cfg_precision = 0; in_valid = 0; in_act = 0; in_w = 0;
    mul_start_acc = 0; mul_sign = 0; mul_exp = 0; mul_mant = 0; res_ready = 0;
    tick();
    tick();
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_o", err_overflow, 0);
    chk("rst_err_s", err_spurious, 0);
    chk("rst_prec", mul_precision, 4);
    chk("rst_mul_act", mul_act, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Single op, prec 4, weight 0101.
    issue(16'h3C00, 8'h05);
    check_stream(16'h3C00, 8'h05, 4, 1'b1);
    chk("t1_idle", mul_valid, 0);
    chk("t1_busy_inflight", busy, 1);
    r = 20'($urandom);
    mul_start_acc = 1'b1;
    {mul_sign, mul_exp, mul_mant} = r;
    #1;
    chk("t1_no_bypass", res_valid, 0);
    tick();
    mul_start_acc = 1'b0;
    exp_q.push_back(r);
    chk("t1_busy_done", busy, 0);
    pop_chk();
    chk("t1_empty", res_valid, 0);

    // Back-to-back ops, then a third that must wait for FIFO credit.
    a0 = 16'($urandom); w0 = 8'($urandom);
    a1 = 16'($urandom); w1 = 8'($urandom);
    a2 = 16'($urandom); w2 = 8'($urandom);
    issue(a0, w0);
    in_valid = 1'b1; in_act = a1; in_w = w1;
    check_stream(a0, w0, 4, 1'b1);
    in_act = a2; in_w = w2;
    check_stream(a1, w1, 4, 1'b0);
    chk("t3_stall_a", in_ready, 0);
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    chk("t3_stall_b", in_ready, 0);
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    chk("t3_stall_c", in_ready, 0);
    tick();
    chk("t3_stall_d", in_ready, 0);
    chk("t3_no_err", err_overflow, 0);
    pop_chk();
    chk("t3_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_stream(a2, w2, 4, 1'b0);
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    pop_chk();
    pop_chk();
    chk("t3_idle_busy", busy, 0);

    // Precision config and clamping; loads while busy are ignored.
    set_prec(4'd9);
    set_prec(4'd1);
    set_prec(4'd0);
    set_prec(4'd5);
    a0 = 16'($urandom); w0 = 8'($urandom);
    issue(a0, w0);
    cfg_load = 1'b1; cfg_precision = 4'd7;
    check_stream(a0, w0, 5, 1'b1);
    tick();
    chk("t4_busy_load_ignored", mul_precision, 5);
    cfg_load = 1'b0;
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    pop_chk();

    // Reset mid-operation.
    set_prec(4'd6);
    issue(16'($urandom), 8'($urandom));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_mul_valid", mul_valid, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_err_o", err_overflow, 0);
    chk("t5_err_s", err_spurious, 0);
    chk("t5_prec", mul_precision, 4);

    // Error flags.
    strobe(20'($urandom));
    chk("t6_spurious", err_spurious, 1);
    chk("t6_no_push", res_valid, 0);
    tick();
    chk("t6_spurious_sticky", err_spurious, 1);
    chk("t6_no_overflow", err_overflow, 0);
    a0 = 16'($urandom); w0 = 8'($urandom);
    issue(a0, w0);
    check_stream(a0, w0, 4, 1'b1);
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    a1 = 16'($urandom); w1 = 8'($urandom);
    issue(a1, w1);
    check_stream(a1, w1, 4, 1'b0);
    r = 20'($urandom); strobe(r); exp_q.push_back(r);
    chk("t6_full_no_err", err_overflow, 0);
    strobe(20'($urandom));
    chk("t6_overflow", err_overflow, 1);
    pop_chk();
    pop_chk();
    chk("t6_drained", res_valid, 0);

    // Randomized precisions, weights and result latency.
    for (int it = 0; it < 16; it++) begin
      cfg_precision = 4'($urandom_range(0, 15));
      prec = clamp(int'(cfg_precision));
      set_prec(cfg_precision);
      a0 = 16'($urandom); w0 = 8'($urandom);
      issue(a0, w0);
      check_stream(a0, w0, prec, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        chk("rnd_gap_idle", mul_valid, 0);
        tick();
      end
      r = 20'($urandom); strobe(r); exp_q.push_back(r);
      pop_chk();
      chk("rnd_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
